// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the two-requester memory arbiter.
//   REQ_M0 / REQ_M1 : requester index, also used as the registered read owner bit
//   DEF_CWIDTH      : default starvation counter width
//   DEF_MAX_WAIT    : default number of denied cycles before requester 1 is forced
package mem_arb_pkg;

    localparam logic REQ_M0 = 1'b0;  // CPU core
    localparam logic REQ_M1 = 1'b1;  // DMA / debug master

    localparam int DEF_CWIDTH   = 4;
    localparam int DEF_MAX_WAIT = 3;

endpackage

// File: rtl/arb2_starve.sv
// arb2_starve: two-way fixed-priority arbiter with a starvation guard.
// Requester 0 wins contention unless requester 1 has already been denied
// MAX_WAIT consecutive cycles, in which case requester 1 is granted once.
//
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset; forces both grants low
//   req0  in  requester 0 request (priority requester)
//   req1  in  requester 1 request
//   gnt0  out requester 0 granted this cycle (combinational)
//   gnt1  out requester 1 granted this cycle (combinational)
import mem_arb_pkg::*;

module arb2_starve #(
    parameter int CWIDTH   = DEF_CWIDTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [CWIDTH-1:0] SAT = CWIDTH'(MAX_WAIT);

    // Consecutive cycles requester 1 has asked and been refused.
    logic [CWIDTH-1:0] r_cnt;
    logic              w_force1;

    assign w_force1 = (r_cnt == SAT);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt1 = req1 && (!req0 || w_force1);
            gnt0 = req0 && !gnt1;
        end
    end

    // Counting only continues while requester 1 keeps asking and losing;
    // a grant or a withdrawn request restarts the wait from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (req1 && !gnt1) begin
            if (!w_force1) begin
                r_cnt <= r_cnt + CWIDTH'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: shares one block RAM (one read port, one write port) between
// the CPU core (m0) and a DMA/debug master (m1). Each port is arbitrated on
// its own by an arb2_starve instance; this level holds the address/data
// muxes and the one-cycle read-return tracking.
//
// Handshake: a requester raises mX_rd_i / mX_wr_i with address (and write
// data) stable and keeps them until the matching mX_rready_o / mX_wready_o
// is high in the same cycle; the transfer happens on that clock edge.
// Ready is combinational from the requests and arbiter state, so a
// requester must never make its request depend on ready.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mX_raddr_i, mX_rd_i             read request from requester X
//   mX_rready_o                     read granted this cycle
//   mX_rdata_o, mX_rvalid_o         read return, one cycle after grant
//   mX_waddr_i, mX_wdata_i, mX_wr_i write request from requester X
//   mX_wready_o                     write granted this cycle
//   mem_raddr_o, mem_rd_o           RAM read port
//   mem_rdata_i                     RAM read data, one cycle after mem_rd_o
//   mem_waddr_o, mem_wdata_o, mem_wr_o  RAM write port
import mem_arb_pkg::*;

module mem_arbiter2 #(
    parameter int AWIDTH   = 16,
    parameter int DWIDTH   = 16,
    parameter int CWIDTH   = DEF_CWIDTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [AWIDTH-1:0] m0_raddr_i,
    input  logic              m0_rd_i,
    output logic              m0_rready_o,
    output logic [DWIDTH-1:0] m0_rdata_o,
    output logic              m0_rvalid_o,
    input  logic [AWIDTH-1:0] m0_waddr_i,
    input  logic [DWIDTH-1:0] m0_wdata_i,
    input  logic              m0_wr_i,
    output logic              m0_wready_o,

    input  logic [AWIDTH-1:0] m1_raddr_i,
    input  logic              m1_rd_i,
    output logic              m1_rready_o,
    output logic [DWIDTH-1:0] m1_rdata_o,
    output logic              m1_rvalid_o,
    input  logic [AWIDTH-1:0] m1_waddr_i,
    input  logic [DWIDTH-1:0] m1_wdata_i,
    input  logic              m1_wr_i,
    output logic              m1_wready_o,

    output logic [AWIDTH-1:0] mem_raddr_o,
    output logic              mem_rd_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic [AWIDTH-1:0] mem_waddr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_wr_o
);

    logic w_rgnt0, w_rgnt1;
    logic w_wgnt0, w_wgnt1;

    // Read-return tracking: a read was granted last cycle, and by whom.
    logic r_rvalid;
    logic r_rowner;

    arb2_starve #(.CWIDTH(CWIDTH), .MAX_WAIT(MAX_WAIT)) u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (m0_rd_i),
        .req1  (m1_rd_i),
        .gnt0  (w_rgnt0),
        .gnt1  (w_rgnt1)
    );

    arb2_starve #(.CWIDTH(CWIDTH), .MAX_WAIT(MAX_WAIT)) u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (m0_wr_i),
        .req1  (m1_wr_i),
        .gnt0  (w_wgnt0),
        .gnt1  (w_wgnt1)
    );

    assign m0_rready_o = w_rgnt0;
    assign m1_rready_o = w_rgnt1;
    assign m0_wready_o = w_wgnt0;
    assign m1_wready_o = w_wgnt1;

    // m0 is the idle default, so only an m1 grant switches the mux.
    assign mem_raddr_o = w_rgnt1 ? m1_raddr_i : m0_raddr_i;
    assign mem_rd_o    = w_rgnt0 | w_rgnt1;
    assign mem_waddr_o = w_wgnt1 ? m1_waddr_i : m0_waddr_i;
    assign mem_wdata_o = w_wgnt1 ? m1_wdata_i : m0_wdata_i;
    assign mem_wr_o    = w_wgnt0 | w_wgnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rowner <= REQ_M0;
        end else begin
            r_rvalid <= w_rgnt0 | w_rgnt1;
            r_rowner <= w_rgnt1 ? REQ_M1 : REQ_M0;
        end
    end

    // Both requesters see the RAM data; only the owner gets valid. Masking
    // with reset drops a read that was in flight when reset arrived.
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign m0_rvalid_o = r_rvalid && !reset && (r_rowner == REQ_M0);
    assign m1_rvalid_o = r_rvalid && !reset && (r_rowner == REQ_M1);

endmodule

// File: tb/tb_mem_arbiter2.sv
module tb_mem_arbiter2;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int MW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_raddr_i, m1_raddr_i, m0_waddr_i, m1_waddr_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic          m0_rd_i, m1_rd_i, m0_wr_i, m1_wr_i;
    logic          m0_rready_o, m1_rready_o, m0_wready_o, m1_wready_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          m0_rvalid_o, m1_rvalid_o;
    logic [AW-1:0] mem_raddr_o, mem_waddr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_rd_o, mem_wr_o;

    mem_arbiter2 #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .m0_raddr_i(m0_raddr_i), .m0_rd_i(m0_rd_i), .m0_rready_o(m0_rready_o),
        .m0_rdata_o(m0_rdata_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_waddr_i(m0_waddr_i), .m0_wdata_i(m0_wdata_i), .m0_wr_i(m0_wr_i),
        .m0_wready_o(m0_wready_o),
        .m1_raddr_i(m1_raddr_i), .m1_rd_i(m1_rd_i), .m1_rready_o(m1_rready_o),
        .m1_rdata_o(m1_rdata_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_waddr_i(m1_waddr_i), .m1_wdata_i(m1_wdata_i), .m1_wr_i(m1_wr_i),
        .m1_wready_o(m1_wready_o),
        .mem_raddr_o(mem_raddr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata_i),
        .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o), .mem_wr_o(mem_wr_o)
    );

    // ---------------- block RAM (environment) ----------------
    // Read-before-write: same-address read sees the old word.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_wr_o) ram[mem_waddr_o[7:0]] <= mem_wdata_o;
        if (mem_rd_o) mem_rdata_i <= ram[mem_raddr_o[7:0]];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] gold [0:255];      // what memory should contain
    int            wait_r, wait_w;    // consecutive m1 denials per port
    logic [DW:0]   exp_q[$];          // {owner, data} expected next cycle
    int            n_vec  = 0;
    int            n_miss = 0;

    // last-cycle observations, used by directed constant checks
    logic          obs_m0_rready, obs_m1_rready, obs_m0_wready, obs_m1_wready;
    logic          obs_m0_rvalid, obs_m1_rvalid;
    logic [DW-1:0] obs_m0_rdata, obs_m1_rdata;
    logic [AW-1:0] obs_raddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Inputs are driven by the caller just after a posedge; this task checks
    // at the following negedge, advances the model, and returns after the
    // next posedge.
    task automatic do_cycle();
        logic          g0r, g1r, g0w, g1w, have, ev0, ev1;
        logic [DW:0]   ent;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        @(negedge clk);
        g1r = !reset && m1_rd_i && (!m0_rd_i || wait_r == MW);
        g0r = !reset && m0_rd_i && !g1r;
        g1w = !reset && m1_wr_i && (!m0_wr_i || wait_w == MW);
        g0w = !reset && m0_wr_i && !g1w;
        ra  = g1r ? m1_raddr_i : m0_raddr_i;
        wa  = g1w ? m1_waddr_i : m0_waddr_i;
        wd  = g1w ? m1_wdata_i : m0_wdata_i;

        chk("m0_rready", m0_rready_o, g0r);
        chk("m1_rready", m1_rready_o, g1r);
        chk("m0_wready", m0_wready_o, g0w);
        chk("m1_wready", m1_wready_o, g1w);
        chk("mem_rd", mem_rd_o, g0r | g1r);
        chk("mem_wr", mem_wr_o, g0w | g1w);
        chk("mem_raddr", mem_raddr_o, ra);
        chk("mem_waddr", mem_waddr_o, wa);
        chk("mem_wdata", mem_wdata_o, wd);

        have = (exp_q.size() != 0);
        ent  = have ? exp_q.pop_front() : '0;
        ev0  = have && !reset && !ent[DW];
        ev1  = have && !reset &&  ent[DW];
        chk("m0_rvalid", m0_rvalid_o, ev0);
        chk("m1_rvalid", m1_rvalid_o, ev1);
        if (ev0) chk("m0_rdata", m0_rdata_o, ent[DW-1:0]);
        if (ev1) chk("m1_rdata", m1_rdata_o, ent[DW-1:0]);

        obs_m0_rready = m0_rready_o;  obs_m1_rready = m1_rready_o;
        obs_m0_wready = m0_wready_o;  obs_m1_wready = m1_wready_o;
        obs_m0_rvalid = m0_rvalid_o;  obs_m1_rvalid = m1_rvalid_o;
        obs_m0_rdata  = m0_rdata_o;   obs_m1_rdata  = m1_rdata_o;
        obs_raddr     = mem_raddr_o;

        // read captures memory contents before this cycle's write
        if (g0r | g1r) exp_q.push_back({g1r, gold[ra[7:0]]});
        if (g0w | g1w) gold[wa[7:0]] = wd;

        if (reset)                 wait_r = 0;
        else if (m1_rd_i && !g1r)  wait_r = (wait_r < MW) ? wait_r + 1 : MW;
        else                       wait_r = 0;
        if (reset)                 wait_w = 0;
        else if (m1_wr_i && !g1w)  wait_w = (wait_w < MW) ? wait_w + 1 : MW;
        else                       wait_w = 0;

        @(posedge clk);
        #1;
    endtask

    // ---------------- driver helpers ----------------
    task automatic idle_inputs();
        m0_rd_i = 1'b0; m1_rd_i = 1'b0; m0_wr_i = 1'b0; m1_wr_i = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            gold[i] = 16'(i * 16'h0101) ^ 16'h5A00;
        end
        gold[8'h40] = 16'hBEEF;
        gold[8'h30] = 16'h0001;
        for (int i = 0; i < 256; i++) ram[i] = gold[i];
        wait_r = 0; wait_w = 0;
        m0_raddr_i = '0; m1_raddr_i = '0; m0_waddr_i = '0; m1_waddr_i = '0;
        m0_wdata_i = '0; m1_wdata_i = '0;
        idle_inputs();

        // reset held 3 cycles with requests present
        reset = 1'b1; m0_rd_i = 1'b1; m1_rd_i = 1'b1; m0_wr_i = 1'b1;
        m0_raddr_i = 16'h0001; m1_raddr_i = 16'h0002; m0_waddr_i = 16'h0003;
        for (int i = 0; i < 3; i++) do_cycle();
        reset = 1'b0; m1_rd_i = 1'b0; m0_wr_i = 1'b0;
        do_cycle();
        chk("release_m0_rready", obs_m0_rready, 1'b1);
        idle_inputs(); do_cycle();

        // m1 lone read of 0x0040
        m1_rd_i = 1'b1; m1_raddr_i = 16'h0040;
        do_cycle();
        chk("lone_m1_rready", obs_m1_rready, 1'b1);
        chk("lone_raddr", obs_raddr, 16'h0040);
        idle_inputs(); do_cycle();
        chk("lone_m1_rvalid", obs_m1_rvalid, 1'b1);
        chk("lone_m1_rdata", obs_m1_rdata, 16'hBEEF);
        chk("lone_m0_rvalid", obs_m0_rvalid, 1'b0);

        // read starvation: m1 forced every 4th cycle
        m0_rd_i = 1'b1; m1_rd_i = 1'b1; m0_raddr_i = 16'h0010; m1_raddr_i = 16'h0020;
        for (int i = 0; i < 8; i++) begin
            do_cycle();
            chk("starve_m1_rready", obs_m1_rready, (i % 4) == 3);
        end
        idle_inputs(); do_cycle();

        // split ports: m0 read with m1 write in one cycle
        m0_rd_i = 1'b1; m0_raddr_i = 16'h0010;
        m1_wr_i = 1'b1; m1_waddr_i = 16'h0020; m1_wdata_i = 16'h1234;
        do_cycle();
        chk("split_m0_rready", obs_m0_rready, 1'b1);
        chk("split_m1_wready", obs_m1_wready, 1'b1);
        idle_inputs(); m0_rd_i = 1'b1; m0_raddr_i = 16'h0020;
        do_cycle();
        idle_inputs(); do_cycle();
        chk("split_readback", obs_m0_rdata, 16'h1234);

        // same-address read/write returns old data
        m0_rd_i = 1'b1; m0_raddr_i = 16'h0030;
        m1_wr_i = 1'b1; m1_waddr_i = 16'h0030; m1_wdata_i = 16'h00FF;
        do_cycle();
        idle_inputs(); m0_rd_i = 1'b1; m0_raddr_i = 16'h0030;
        do_cycle();
        chk("hazard_old", obs_m0_rdata, 16'h0001);
        idle_inputs(); do_cycle();
        chk("hazard_new", obs_m0_rdata, 16'h00FF);

        // reset mid-operation: write counter at 2, m1 read in flight
        m0_wr_i = 1'b1; m1_wr_i = 1'b1;
        m0_waddr_i = 16'h0050; m1_waddr_i = 16'h0051;
        m0_wdata_i = 16'hAAAA; m1_wdata_i = 16'h5555;
        do_cycle();
        m1_rd_i = 1'b1; m1_raddr_i = 16'h0040;
        do_cycle();
        reset = 1'b1;
        do_cycle();
        chk("midrst_m1_rvalid", obs_m1_rvalid, 1'b0);
        reset = 1'b0; m1_rd_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            chk("midrst_m1_wready", obs_m1_wready, i == 3);
        end
        idle_inputs(); do_cycle();

        // randomized traffic with held-until-ready requests
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            if (!(m0_rd_i && !obs_m0_rready)) begin
                m0_rd_i = ($urandom_range(0, 3) != 0);
                m0_raddr_i = 16'($urandom_range(0, 15));
            end
            if (!(m1_rd_i && !obs_m1_rready)) begin
                m1_rd_i = ($urandom_range(0, 3) != 0);
                m1_raddr_i = 16'($urandom_range(0, 15));
            end
            if (!(m0_wr_i && !obs_m0_wready)) begin
                m0_wr_i = ($urandom_range(0, 2) != 0);
                m0_waddr_i = 16'($urandom_range(0, 15));
                m0_wdata_i = 16'($urandom);
            end
            if (!(m1_wr_i && !obs_m1_wready)) begin
                m1_wr_i = ($urandom_range(0, 2) != 0);
                m1_waddr_i = 16'($urandom_range(0, 15));
                m1_wdata_i = 16'($urandom);
            end
            do_cycle();
        end
        reset = 1'b0; idle_inputs(); do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
